// File: rtl/rho_stage.sv
// Keccak-f[1600] rho stage: buffers a 64x25 slice-organised state, writes lane-rotated slices downstream.
// Latency: start sampled in IDLE at cycle 0, 64 read + 1 capture + 64 write cycles, Done pulses at cycle 130.
// No backpressure: start is ignored unless Ready; upstream/downstream memories must serve every cycle.
module rho_stage #(
  parameter int SLICE_W = 25,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               Ready,
  output logic               Done,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SLICE_W-1:0] rd_data,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SLICE_W-1:0] wr_data,
  output logic               wr_en
);

  localparam int NUM_SLICES = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;

  // Slice counter shared by the read and write sweeps.
  logic [ADDR_W-1:0] k;
  logic              k_last;

  // State buffer: one 64-bit lane per bit position i = 5*y + x.
  logic [NUM_SLICES-1:0] lane_q [SLICE_W];

  logic              cap_en;
  logic [ADDR_W-1:0] cap_idx;
  logic [SLICE_W-1:0] rot_slice;
  logic [ADDR_W-1:0] src_z;

  // Rotation offset r[x][y] for the lane stored at bit i = 5*y + x.
  function automatic logic [5:0] rho_off(input int i);
    logic [5:0] r;
    case (i)
      0:  r = 6'd0;   // x0 y0
      1:  r = 6'd1;   // x1 y0
      2:  r = 6'd62;  // x2 y0
      3:  r = 6'd28;  // x3 y0
      4:  r = 6'd27;  // x4 y0
      5:  r = 6'd36;  // x0 y1
      6:  r = 6'd44;  // x1 y1
      7:  r = 6'd6;   // x2 y1
      8:  r = 6'd55;  // x3 y1
      9:  r = 6'd20;  // x4 y1
      10: r = 6'd3;   // x0 y2
      11: r = 6'd10;  // x1 y2
      12: r = 6'd43;  // x2 y2
      13: r = 6'd25;  // x3 y2
      14: r = 6'd39;  // x4 y2
      15: r = 6'd41;  // x0 y3
      16: r = 6'd45;  // x1 y3
      17: r = 6'd15;  // x2 y3
      18: r = 6'd21;  // x3 y3
      19: r = 6'd8;   // x4 y3
      20: r = 6'd18;  // x0 y4
      21: r = 6'd2;   // x1 y4
      22: r = 6'd61;  // x2 y4
      23: r = 6'd56;  // x3 y4
      24: r = 6'd14;  // x4 y4
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign k_last = &k;

  // Read data lags rd_addr by one cycle, so the slice landing now belongs to address k-1;
  // the CAPTURE cycle (k already wrapped to 0) picks up slice 63 the same way.
  assign cap_en  = ((state == S_READ) && (k != '0)) || (state == S_CAPTURE);
  assign cap_idx = k - 1'b1;

  // Buffer fill: no reset, contents only meaningful after a complete read sweep.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < SLICE_W; i++) begin
        lane_q[i][cap_idx] <= rd_data[i];
      end
    end
  end

  // Output slice k gathers, per lane, bit (k - r) mod 64; 6-bit subtraction wraps naturally.
  always_comb begin
    rot_slice = '0;
    src_z     = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      src_z        = k - rho_off(i);
      rot_slice[i] = lane_q[i][src_z];
    end
  end

  // Data bus stays quiet whenever no write is being issued.
  assign wr_data = wr_en ? rot_slice : '0;

  // Control FSM: sequences read sweep, capture, write sweep and the Done pulse; outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      k       <= '0;
      Ready   <= 1'b1;
      Done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_READ;
            k       <= '0;
            Ready   <= 1'b0;
            rd_addr <= '0;
          end
        end
        S_READ: begin
          k <= k + 1'b1;
          if (k_last) begin
            state   <= S_CAPTURE;
            rd_addr <= '0;
          end else begin
            rd_addr <= k + 1'b1;
          end
        end
        S_CAPTURE: begin
          state   <= S_WRITE;
          k       <= '0;
          wr_en   <= 1'b1;
          wr_addr <= '0;
        end
        S_WRITE: begin
          if (k_last) begin
            state   <= S_DONE;
            k       <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            Done    <= 1'b1;
          end else begin
            k       <= k + 1'b1;
            wr_addr <= k + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Done  <= 1'b0;
          Ready <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          k       <= '0;
          Ready   <= 1'b1;
          Done    <= 1'b0;
          wr_en   <= 1'b0;
          wr_addr <= '0;
          rd_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rho_stage.md
Name: rho_stage

Overview:
- Keccak-f[1600] rho (lane rotation) stage; sits directly downstream of the column-parity/theta stage.
- Consumes the slice-organised state memory that theta writes: 64 slices × 25 bits, one slice per address.
- Buffers the full state, then writes 64 rho-rotated slices to the next stage's memory.
- Same start/Ready/Done handshake as the other round stages, so stages chain by tying Done(n) to start(n+1).

Parameters:
- SLICE_W, 25: bits per slice (5×5 lanes). Fixed by the algorithm; no other value supported.
- ADDR_W, 6: slice address width (64 slices). Fixed; no other value supported.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request to process one state; sampled only in IDLE
- Ready  output  1  high while in IDLE
- Done  output  1  one-cycle pulse when the output memory is fully written
- rd_addr  output  6  slice address to upstream memory
- rd_data  input  25  slice data from upstream memory; synchronous read, valid the cycle after rd_addr
- wr_addr  output  6  slice address to downstream memory
- wr_data  output  25  rotated slice data
- wr_en  output  1  write strobe to downstream memory

Behaviour:
Bit mapping (all memories):
- Bit index i = 5*y + x holds lane A[x][y] at slice z.

Rotation:
- Output slice z, bit (x,y) = input slice (z − r[x][y]) mod 64, bit (x,y). Equivalently, input slice z moves to output slice (z + r) mod 64.
- Subtraction is done modulo 64 on 6 bits; wrap-around is natural truncation.
- Offsets r[x][y], listed for y = 0..4:
  - x=0: 0, 36, 3, 41, 18
  - x=1: 1, 44, 10, 45, 2
  - x=2: 62, 6, 43, 15, 61
  - x=3: 28, 55, 25, 21, 56
  - x=4: 27, 20, 39, 8, 14

Storage:
- 1600-bit internal buffer, organised as 25 lanes × 64 bits.
- Buffer is not cleared by reset; contents are don't-care until a READ phase completes.

FSM (counter k, 6 bits, plus 1 wrap flag):
- IDLE: Ready=1. start=1 → READ, k←0. Otherwise stay.
- READ: rd_addr=k. If k≥1, capture rd_data into buffer slice k−1. k increments each cycle. After the k=63 cycle → CAPTURE.
- CAPTURE: capture rd_data into slice 63; k←0 → WRITE.
- WRITE: wr_en=1, wr_addr=k, wr_data=rotated slice k (combinational from buffer). k increments. After the k=63 cycle → DONE.
- DONE: Done=1 for exactly one cycle → IDLE.

Timing (start sampled in IDLE at cycle 0):
- READ cycles 1–64
- CAPTURE cycle 65
- WRITE cycles 66–129
- Done=1 at cycle 130
- Ready=1 again at cycle 131

Output values outside their active states:
- rd_addr=k in READ, 0 otherwise.
- wr_addr and wr_data are 0 when wr_en=0.
- Done, wr_en=0 except in the states above.

Reset values:
- FSM=IDLE, k=0, Ready=1, Done=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0.

Boundary conditions:
- start while not IDLE: ignored; no restart, no queuing.
- start held high through DONE: a new pass begins on the first IDLE cycle (cycle 131).
- reset mid-READ/WRITE: immediate return to IDLE, wr_en drops asynchronously. Downstream memory keeps the partial writes; no Done is issued.
- Each output address is written exactly once per pass, in ascending order 0..63.

Test Plan:
- Identity lane: slice 0 = 25'h0000001 (A[0][0] bit 0), all other slices 0 → output slice 0 = 25'h0000001; all other output slices 0; Done at cycle 130.
- Offset 1: slice 0 = 25'h0000002 (A[1][0]) → output slice 1 = 25'h0000002; all others 0.
- Wrap-around: slice 40 = 25'h0000020 (A[0][1], r=36) → output slice 12 = 25'h0000020. Separately, slice 5 = 25'h0000004 (A[2][0], r=62) → output slice 3.
- All-ones state → all 64 output slices = 25'h1FFFFFF. Random state → matches a golden rho model bit-exactly. Two back-to-back passes with start held high → second Done at cycle 261.
- Busy handling: pulse start at cycles 10 and 100 → ignored, exactly one Done at 130. Assert reset at cycle 80 → wr_en=0 and Ready=1 immediately, no Done; a fresh start completes correctly.
